// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_HIGH = 2'd1,
    CAP_LOW  = 2'd2
  } cap_state_t;

  localparam int   PWM_CNT_W   = 16;
  localparam logic PWM_DIR_FWD = 1'b1;

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// Multi-flop synchronizer with registered rise/fall pulses on the synchronized level.
// Edges are only reported once the chain holds real input samples and the level
// has been seen low, so a line that is already high when reset releases does not
// look like a fresh rising edge.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   fill_q;
  logic              prev_q;
  logic              armed_q;
  logic              rise_q;
  logic              fall_q;

  // Synchronizer chain, edge-detect register and registered edge pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
      prev_q <= sync_q[STAGES-1];
      if (fill_q[STAGES] && !sync_q[STAGES-1]) begin
        armed_q <= 1'b1;
      end
      rise_q <= armed_q &  sync_q[STAGES-1] & ~prev_q;
      fall_q <= armed_q & ~sync_q[STAGES-1] &  prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM line,
// with direction sampled at each measurement and a no-edge timeout.
//
// state    | meaning
// CAP_IDLE | waiting for the first rise of a new measurement
// CAP_HIGH | pulse high, counting towards the falling edge
// CAP_LOW  | pulse low, counting towards the next rise (publishes)
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK100MHZ,
  input  logic             rst,
  input  logic             en,
  input  logic             spd_in,
  input  logic             dir_in,
  output logic [CNT_W-1:0] high_ticks,
  output logic [CNT_W-1:0] period_ticks,
  output logic             dir_out,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic spd_level, spd_rise, spd_fall;
  logic dir_level, dir_rise_nc, dir_fall_nc;

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             at_max;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_spd_sync (
    .clk_i  (CLK100MHZ),
    .rst_i  (rst),
    .d_i    (spd_in),
    .level_o(spd_level),
    .rise_o (spd_rise),
    .fall_o (spd_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_dir_sync (
    .clk_i  (CLK100MHZ),
    .rst_i  (rst),
    .d_i    (dir_in),
    .level_o(dir_level),
    .rise_o (dir_rise_nc),
    .fall_o (dir_fall_nc)
  );

  assign pcnt_inc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
  assign at_max   = (pcnt_q == CNT_MAX);

  // State register.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) state_q <= CAP_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a qualifying edge always takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = CAP_IDLE;
    end else begin
      case (state_q)
        CAP_IDLE: if (spd_rise) state_d = CAP_HIGH;
        CAP_HIGH: begin
          if (spd_fall)    state_d = CAP_LOW;
          else if (at_max) state_d = CAP_IDLE;
        end
        CAP_LOW: begin
          if (spd_rise)    state_d = CAP_HIGH;
          else if (at_max) state_d = CAP_IDLE;
        end
        default: state_d = CAP_IDLE;
      endcase
    end
  end

  // Counter updates and publication of measurements / timeout reports.
  always_comb begin
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    high_d    = high_q;
    period_d  = period_q;
    dir_d     = dir_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!en) begin
      pcnt_d = '0;
      hcnt_d = '0;
    end else begin
      case (state_q)
        CAP_IDLE: begin
          if (spd_rise) begin
            pcnt_d = CNT_ONE;
          end else begin
            pcnt_d = pcnt_inc;
            // Report a dead line once; stay quiet until a full period completes.
            if (at_max && !timeout_q) begin
              high_d    = spd_level ? CNT_MAX : '0;
              period_d  = CNT_MAX;
              dir_d     = dir_level;
              valid_d   = 1'b1;
              timeout_d = 1'b1;
            end
          end
        end
        CAP_HIGH: begin
          if (spd_fall) begin
            hcnt_d = pcnt_q;
            pcnt_d = pcnt_inc;
          end else if (at_max) begin
            high_d    = spd_level ? CNT_MAX : '0;
            period_d  = CNT_MAX;
            dir_d     = dir_level;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            pcnt_d    = '0;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        CAP_LOW: begin
          if (spd_rise) begin
            high_d    = hcnt_q;
            period_d  = pcnt_q;
            dir_d     = dir_level;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            pcnt_d    = CNT_ONE;
          end else if (at_max) begin
            high_d    = spd_level ? CNT_MAX : '0;
            period_d  = CNT_MAX;
            dir_d     = dir_level;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            pcnt_d    = '0;
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
        default: pcnt_d = '0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      high_q    <= '0;
      period_q  <= '0;
      dir_q     <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      high_q    <= high_d;
      period_q  <= period_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign high_ticks   = high_q;
  assign period_ticks = period_q;
  assign dir_out      = dir_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and randomized PWM waveforms checked against
// an edge-timestamp reference model (report = fall-rise / rise-rise, SYNC+1 late).
module tb_pwm_capture;

  localparam int CW  = 10;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;
  localparam int ALL = (1 << CW) - 1;

  logic          CLK100MHZ = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          spd_in = 1'b0;
  logic          dir_in = 1'b0;
  logic [CW-1:0] high_ticks, period_ticks;
  logic          dir_out, valid, timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   at;
    int   hi;
    int   per;
    logic d;
  } exp_t;
  exp_t expq[$];

  logic m_prev = 1'b0;
  int   m_rise = -1;
  int   m_fall = -1;
  bit   m_chk = 1'b1;
  int   n_valid = 0;
  int   v_hi = 0, v_per = 0, v_tmo = 0;

  pwm_capture #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .CLK100MHZ   (CLK100MHZ),
    .rst         (rst),
    .en          (en),
    .spd_in      (spd_in),
    .dir_in      (dir_in),
    .high_ticks  (high_ticks),
    .period_ticks(period_ticks),
    .dir_out     (dir_out),
    .valid       (valid),
    .timeout     (timeout)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, let the DUT sample them, update model, check.
  task automatic step(input logic s, input logic d);
    bit ev;
    spd_in = s;
    dir_in = d;
    @(posedge CLK100MHZ);
    if (rst || !en) begin
      m_rise = -1;
      m_fall = -1;
    end else begin
      if (s && !m_prev) begin
        if (m_rise >= 0 && m_fall > m_rise)
          expq.push_back('{cyc + LAT, m_fall - m_rise, cyc - m_rise, d});
        m_rise = cyc;
      end
      if (!s && m_prev && m_rise >= 0) m_fall = cyc;
    end
    m_prev = s;
    #1;
    ev = (expq.size() > 0) && (expq[0].at == cyc);
    if (m_chk) begin
      chk("valid", {31'd0, valid}, {31'd0, ev});
      if (ev) begin
        chk("high_ticks", 32'(high_ticks), 32'(expq[0].hi));
        chk("period_ticks", 32'(period_ticks), 32'(expq[0].per));
        chk("dir_out", {31'd0, dir_out}, {31'd0, expq[0].d});
        chk("timeout_on_publish", {31'd0, timeout}, 32'd0);
      end
    end else if (valid) begin
      n_valid++;
      v_hi  = int'(high_ticks);
      v_per = int'(period_ticks);
      v_tmo = int'(timeout);
    end
    if (ev) void'(expq.pop_front());
    cyc++;
  endtask

  task automatic pwm(input int hi, input int per, input logic d, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < per; i++)
        step(i < hi, d);
  endtask

  initial begin
    // Reset state.
    repeat (3) step(1'b0, 1'b0);
    chk("rst_high_ticks", 32'(high_ticks), 32'd0);
    chk("rst_period_ticks", 32'(period_ticks), 32'd0);
    chk("rst_dir_out", {31'd0, dir_out}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (20) step(1'b0, 1'b1);

    // Steady 100/1000 forward, then duty change to 750.
    pwm(100, 1000, 1'b1, 4);
    pwm(750, 1000, 1'b1, 3);

    // Randomized periods, duties and direction.
    for (int k = 0; k < 8; k++) begin
      int per, hi;
      logic d;
      per = int'($urandom_range(1000, 20));
      hi  = int'($urandom_range(per - 1, 1));
      d   = logic'($urandom_range(1, 0));
      pwm(hi, per, d, 1);
    end
    pwm(100, 1000, 1'b1, 2);

    // Enable dropped mid low-phase while dir flips; outputs must hold.
    for (int i = 0; i < 300; i++) step(i < 100, 1'b1);
    en = 1'b0;
    repeat (50) step(1'b0, 1'b0);
    chk("en_hold_high", 32'(high_ticks), 32'd100);
    chk("en_hold_period", 32'(period_ticks), 32'd1000);
    chk("en_hold_dir", {31'd0, dir_out}, 32'd1);
    en = 1'b1;
    repeat (650) step(1'b0, 1'b0);
    pwm(100, 1000, 1'b0, 3);

    // Reset in the middle of a high phase.
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_high_ticks", 32'(high_ticks), 32'd0);
    chk("midrst_period_ticks", 32'(period_ticks), 32'd0);
    chk("midrst_dir_out", {31'd0, dir_out}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_timeout", {31'd0, timeout}, 32'd0);
    expq.delete();
    repeat (3) step(1'b1, 1'b0);
    rst = 1'b0;
    repeat (47) step(1'b1, 1'b0);
    repeat (900) step(1'b0, 1'b0);
    pwm(100, 1000, 1'b0, 3);

    // Line stuck low: one timeout report, then silence.
    pwm(200, 400, 1'b0, 3);
    m_chk = 1'b0;
    n_valid = 0;
    repeat (1500) step(1'b0, 1'b0);
    chk("tmo_low_count", 32'(n_valid), 32'd1);
    chk("tmo_low_high", 32'(v_hi), 32'd0);
    chk("tmo_low_period", 32'(v_per), 32'(ALL));
    chk("tmo_low_flag", 32'(v_tmo), 32'd1);
    m_chk = 1'b1;
    m_rise = -1;
    m_fall = -1;
    expq.delete();
    pwm(200, 400, 1'b0, 1);
    chk("tmo_sticky", {31'd0, timeout}, 32'd1);
    pwm(200, 400, 1'b0, 2);
    chk("tmo_cleared", {31'd0, timeout}, 32'd0);

    // Line stuck high.
    repeat (10) step(1'b1, 1'b0);
    m_chk = 1'b0;
    n_valid = 0;
    repeat (1500) step(1'b1, 1'b0);
    chk("tmo_high_count", 32'(n_valid), 32'd1);
    chk("tmo_high_high", 32'(v_hi), 32'(ALL));
    chk("tmo_high_period", 32'(v_per), 32'(ALL));
    chk("tmo_high_flag", 32'(v_tmo), 32'd1);
    chk("tmo_high_sticky", {31'd0, timeout}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
